// File: rtl/ex_div_pkg.sv
// Shared constants, state encoding and funct3 decode helpers for the RV32M divider.
package ex_div_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;

  localparam logic [REG_BUS-1:0]      ZERO_WORD = '0;
  localparam logic [REG_ADDR_BUS-1:0] ZERO_REG  = '0;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_CALC,
    S_END
  } div_state_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == INST_DIV) || (op == INST_DIVU) || (op == INST_REM) || (op == INST_REMU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == INST_DIV) || (op == INST_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] op);
    return (op == INST_REM) || (op == INST_REMU);
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// Execute-stage to divider handshake: request, operands, flush and the result/status return.
interface ex_div_if;
  import ex_div_pkg::*;

  logic                    start_i;
  logic [2:0]              op_i;
  logic [REG_BUS-1:0]      dividend_i;
  logic [REG_BUS-1:0]      divisor_i;
  logic [REG_ADDR_BUS-1:0] reg_waddr_i;
  logic                    flush_i;
  logic [REG_BUS-1:0]      result_o;
  logic                    ready_o;
  logic                    busy_o;
  logic [REG_ADDR_BUS-1:0] reg_waddr_o;

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    output result_o, ready_o, busy_o, reg_waddr_o
  );

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, flush_i,
    input  result_o, ready_o, busy_o, reg_waddr_o
  );

endinterface

// File: rtl/ex_div.sv
// Restoring 32-bit divider for div/divu/rem/remu, one quotient bit per clock.
// Signed operands are divided as magnitudes and the signs are fixed up on the way into END.
module ex_div
  import ex_div_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave bus
);

  localparam logic [5:0] CNT_LAST = 6'd31;

  div_state_t state, state_next;

  logic [REG_BUS-1:0]      dvd_q, rem_q, dsr_q, result_q;
  logic [2:0]              op_q;
  logic [REG_ADDR_BUS-1:0] waddr_q, waddr_out_q;
  logic [5:0]              cnt_q;
  logic                    qneg_q, rneg_q;

  logic                    start_ok, signed_op, div_zero, overflow, qbit;
  logic [REG_BUS:0]        shifted, trial;
  logic [REG_BUS-1:0]      rem_step, quo_step, quo_fix, rem_fix, final_res;
  logic [REG_BUS-1:0]      dvd_abs, dsr_abs;

  always_comb begin
    start_ok  = bus.start_i & is_div_op(bus.op_i) & ~bus.flush_i;
    signed_op = is_signed_op(op_q);
    div_zero  = (dsr_q == ZERO_WORD);
    overflow  = signed_op && (dvd_q == 32'h8000_0000) && (dsr_q == 32'hFFFF_FFFF);
    dvd_abs   = (signed_op && dvd_q[31]) ? -dvd_q : dvd_q;
    dsr_abs   = (signed_op && dsr_q[31]) ? -dsr_q : dsr_q;
    // A set top bit in the shifted remainder already guarantees it exceeds the divisor.
    shifted   = {rem_q, dvd_q[31]};
    trial     = shifted - {1'b0, dsr_q};
    qbit      = shifted[REG_BUS] | ~trial[REG_BUS];
    rem_step  = qbit ? trial[REG_BUS-1:0] : shifted[REG_BUS-1:0];
    quo_step  = {dvd_q[REG_BUS-2:0], qbit};
    quo_fix   = qneg_q ? -quo_step : quo_step;
    rem_fix   = rneg_q ? -rem_step : rem_step;
    final_res = is_rem_op(op_q) ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_ok) state_next = S_START;
      S_START: begin
        if (bus.flush_i)                state_next = S_IDLE;
        else if (div_zero || overflow)  state_next = S_END;
        else                            state_next = S_CALC;
      end
      S_CALC: begin
        if (bus.flush_i)                state_next = S_IDLE;
        else if (cnt_q == CNT_LAST)     state_next = S_END;
      end
      S_END:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Result and destination only update on a completed operation, so a flush leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q       <= ZERO_WORD;
      rem_q       <= ZERO_WORD;
      dsr_q       <= ZERO_WORD;
      result_q    <= ZERO_WORD;
      op_q        <= 3'b000;
      waddr_q     <= ZERO_REG;
      waddr_out_q <= ZERO_REG;
      cnt_q       <= 6'd0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            dvd_q   <= bus.dividend_i;
            dsr_q   <= bus.divisor_i;
            op_q    <= bus.op_i;
            waddr_q <= bus.reg_waddr_i;
          end
        end
        S_START: begin
          if (!bus.flush_i) begin
            if (div_zero) begin
              result_q    <= is_rem_op(op_q) ? dvd_q : 32'hFFFF_FFFF;
              waddr_out_q <= waddr_q;
            end else if (overflow) begin
              result_q    <= is_rem_op(op_q) ? ZERO_WORD : 32'h8000_0000;
              waddr_out_q <= waddr_q;
            end else begin
              dvd_q  <= dvd_abs;
              dsr_q  <= dsr_abs;
              rem_q  <= ZERO_WORD;
              cnt_q  <= 6'd0;
              qneg_q <= signed_op & (dvd_q[31] ^ dsr_q[31]);
              rneg_q <= signed_op & dvd_q[31];
            end
          end
        end
        S_CALC: begin
          if (!bus.flush_i) begin
            dvd_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == CNT_LAST) begin
              result_q    <= final_res;
              waddr_out_q <= waddr_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o    = result_q;
  assign bus.reg_waddr_o = waddr_out_q;
  assign bus.ready_o     = (state == S_END);
  assign bus.busy_o      = (state == S_START) || (state == S_CALC);

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, signed/unsigned results, special cases, flush and async reset.
module tb_ex_div;
  import ex_div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] prev_res;
  logic [4:0]  prev_rd;

  ex_div_if io ();

  ex_div dut (
    .clk (clk),
    .rst (rst),
    .bus (io.slave)
  );

  always #5 clk = ~clk;

  // Issues one operation in an IDLE cycle and returns clocks to ready (sample edge counts as 1) and busy cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int busy_cnt);
    @(negedge clk);
    if (io.ready_o) @(negedge clk);
    io.start_i     = 1'b1;
    io.op_i        = op;
    io.dividend_i  = a;
    io.divisor_i   = b;
    io.reg_waddr_i = rd;
    lat      = 0;
    busy_cnt = 0;
    @(posedge clk);
    lat = 1;
    #1;
    io.start_i     = 1'b0;
    io.dividend_i  = $urandom();
    io.divisor_i   = $urandom();
    io.reg_waddr_i = 5'($urandom());
    if (io.busy_o) busy_cnt++;
    while (io.ready_o !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (io.busy_o) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (io.result_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected %h", io.result_o, 32'h0); end
    checks++; if (io.ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", io.ready_o); end
    checks++; if (io.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", io.busy_o); end
    checks++; if (io.reg_waddr_o !== 5'd0) begin errors++; $display("[TB] FAIL reset_waddr: got %0d expected 0", io.reg_waddr_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_div_basic();
    int lat, bc;
    run_op(INST_DIV, 32'd100, 32'd7, 5'd5, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL div_latency: got %0d expected 34", lat); end
    checks++; if (io.result_o !== 32'd14) begin errors++; $display("[TB] FAIL div_100_7: got %h expected %h", io.result_o, 32'd14); end
    checks++; if (io.reg_waddr_o !== 5'd5) begin errors++; $display("[TB] FAIL div_waddr: got %0d expected 5", io.reg_waddr_o); end
    checks++; if (bc !== 33) begin errors++; $display("[TB] FAIL div_busy_cycles: got %0d expected 33", bc); end
    checks++; if (io.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL div_busy_at_ready: got %b expected 0", io.busy_o); end
    @(posedge clk); #1;
    checks++; if (io.ready_o !== 1'b0) begin errors++; $display("[TB] FAIL ready_width: got %b expected 0", io.ready_o); end
    checks++; if (io.result_o !== 32'd14) begin errors++; $display("[TB] FAIL result_hold: got %h expected %h", io.result_o, 32'd14); end
  endtask

  task automatic test_signed();
    int lat, bc;
    run_op(INST_REM, 32'hFFFF_FF9C, 32'd7, 5'd6, lat, bc);
    checks++; if (io.result_o !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL rem_m100_7: got %h expected %h", io.result_o, 32'hFFFF_FFFE); end
    run_op(INST_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd7, lat, bc);
    checks++; if (io.result_o !== 32'd14) begin errors++; $display("[TB] FAIL div_m100_m7: got %h expected %h", io.result_o, 32'd14); end
    run_op(INST_DIV, 32'd100, 32'hFFFF_FFF9, 5'd8, lat, bc);
    checks++; if (io.result_o !== 32'hFFFF_FFF2) begin errors++; $display("[TB] FAIL div_100_m7: got %h expected %h", io.result_o, 32'hFFFF_FFF2); end
    run_op(INST_REM, 32'd100, 32'hFFFF_FFF9, 5'd8, lat, bc);
    checks++; if (io.result_o !== 32'd2) begin errors++; $display("[TB] FAIL rem_100_m7: got %h expected %h", io.result_o, 32'd2); end
  endtask

  task automatic test_unsigned();
    int lat, bc;
    run_op(INST_DIVU, 32'hFFFF_FFFF, 32'd2, 5'd10, lat, bc);
    checks++; if (io.result_o !== 32'h7FFF_FFFF) begin errors++; $display("[TB] FAIL divu_max_2: got %h expected %h", io.result_o, 32'h7FFF_FFFF); end
    run_op(INST_REMU, 32'hFFFF_FFFF, 32'd2, 5'd11, lat, bc);
    checks++; if (io.result_o !== 32'd1) begin errors++; $display("[TB] FAIL remu_max_2: got %h expected %h", io.result_o, 32'd1); end
    run_op(INST_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 5'd12, lat, bc);
    checks++; if (io.result_o !== 32'd1) begin errors++; $display("[TB] FAIL divu_big: got %h expected %h", io.result_o, 32'd1); end
    run_op(INST_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 5'd12, lat, bc);
    checks++; if (io.result_o !== 32'h7FFF_FFFE) begin errors++; $display("[TB] FAIL remu_big: got %h expected %h", io.result_o, 32'h7FFF_FFFE); end
  endtask

  task automatic test_special();
    int lat, bc;
    run_op(INST_DIV, 32'd5, 32'd0, 5'd13, lat, bc);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL div0_latency: got %0d expected 2", lat); end
    checks++; if (io.result_o !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_5_0: got %h expected %h", io.result_o, 32'hFFFF_FFFF); end
    checks++; if (io.reg_waddr_o !== 5'd13) begin errors++; $display("[TB] FAIL div0_waddr: got %0d expected 13", io.reg_waddr_o); end
    run_op(INST_REM, 32'd5, 32'd0, 5'd14, lat, bc);
    checks++; if (io.result_o !== 32'd5) begin errors++; $display("[TB] FAIL rem_5_0: got %h expected %h", io.result_o, 32'd5); end
    run_op(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, lat, bc);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL ovf_latency: got %0d expected 2", lat); end
    checks++; if (io.result_o !== 32'h8000_0000) begin errors++; $display("[TB] FAIL div_ovf: got %h expected %h", io.result_o, 32'h8000_0000); end
    run_op(INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, lat, bc);
    checks++; if (io.result_o !== 32'd0) begin errors++; $display("[TB] FAIL rem_ovf: got %h expected %h", io.result_o, 32'd0); end
    run_op(INST_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL divu_noovf_latency: got %0d expected 34", lat); end
    checks++; if (io.result_o !== 32'd0) begin errors++; $display("[TB] FAIL divu_noovf: got %h expected %h", io.result_o, 32'd0); end
  endtask

  task automatic test_ignored_start();
    int busy_seen = 0;
    @(negedge clk);
    if (io.ready_o) @(negedge clk);
    io.start_i = 1'b1; io.op_i = 3'b000; io.dividend_i = 32'd9; io.divisor_i = 32'd3;
    @(negedge clk);
    io.op_i = INST_DIV; io.flush_i = 1'b1;
    @(negedge clk);
    io.start_i = 1'b0; io.flush_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (io.busy_o) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("[TB] FAIL ignored_start_busy: got %0d expected 0", busy_seen); end
    checks++; if (io.result_o !== 32'd0) begin errors++; $display("[TB] FAIL ignored_start_result: got %h expected %h", io.result_o, 32'd0); end
  endtask

  task automatic test_flush();
    int lat, bc, ready_seen;
    prev_res = io.result_o;
    prev_rd  = io.reg_waddr_o;
    @(negedge clk);
    io.start_i = 1'b1; io.op_i = INST_DIV; io.dividend_i = 32'd1000; io.divisor_i = 32'd3; io.reg_waddr_i = 5'd20;
    @(posedge clk); #1;
    io.start_i = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    io.flush_i = 1'b1;
    @(posedge clk); #1;
    io.flush_i = 1'b0;
    checks++; if (io.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b expected 0", io.busy_o); end
    ready_seen = 0;
    repeat (4) begin
      if (io.ready_o) ready_seen++;
      @(posedge clk); #1;
    end
    checks++; if (ready_seen !== 0) begin errors++; $display("[TB] FAIL flush_ready: got %0d expected 0", ready_seen); end
    checks++; if (io.result_o !== prev_res) begin errors++; $display("[TB] FAIL flush_result_hold: got %h expected %h", io.result_o, prev_res); end
    checks++; if (io.reg_waddr_o !== prev_rd) begin errors++; $display("[TB] FAIL flush_waddr_hold: got %0d expected %0d", io.reg_waddr_o, prev_rd); end
    run_op(INST_DIVU, 32'd9, 32'd3, 5'd3, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL post_flush_latency: got %0d expected 34", lat); end
    checks++; if (io.result_o !== 32'd3) begin errors++; $display("[TB] FAIL post_flush_result: got %h expected %h", io.result_o, 32'd3); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_op(INST_REMU, 32'd1000, 32'd7, 5'd21, lat, bc);
    checks++; if (io.result_o !== 32'd6) begin errors++; $display("[TB] FAIL b2b_first: got %h expected %h", io.result_o, 32'd6); end
    run_op(INST_DIVU, 32'd1000, 32'd7, 5'd22, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 34", lat); end
    checks++; if (io.result_o !== 32'd142) begin errors++; $display("[TB] FAIL b2b_second: got %h expected %h", io.result_o, 32'd142); end
    checks++; if (io.reg_waddr_o !== 5'd22) begin errors++; $display("[TB] FAIL b2b_waddr: got %0d expected 22", io.reg_waddr_o); end
  endtask

  task automatic test_async_reset();
    int lat, bc;
    @(negedge clk);
    io.start_i = 1'b1; io.op_i = INST_DIV; io.dividend_i = 32'd500; io.divisor_i = 32'd7; io.reg_waddr_i = 5'd25;
    @(posedge clk); #1;
    io.start_i = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (io.result_o !== 32'd0) begin errors++; $display("[TB] FAIL arst_result: got %h expected %h", io.result_o, 32'd0); end
    checks++; if (io.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_busy: got %b expected 0", io.busy_o); end
    checks++; if (io.ready_o !== 1'b0) begin errors++; $display("[TB] FAIL arst_ready: got %b expected 0", io.ready_o); end
    checks++; if (io.reg_waddr_o !== 5'd0) begin errors++; $display("[TB] FAIL arst_waddr: got %0d expected 0", io.reg_waddr_o); end
    @(negedge clk);
    rst = 1'b0;
    run_op(INST_DIV, 32'd100, 32'd7, 5'd26, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d expected 34", lat); end
    checks++; if (io.result_o !== 32'd14) begin errors++; $display("[TB] FAIL post_reset_result: got %h expected %h", io.result_o, 32'd14); end
  endtask

  initial begin
    io.start_i = 1'b0; io.op_i = 3'b000; io.dividend_i = '0; io.divisor_i = '0;
    io.reg_waddr_i = '0; io.flush_i = 1'b0;
    test_reset();
    test_ignored_start();
    test_div_basic();
    test_signed();
    test_unsigned();
    test_special();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
